conv_window_gen: RTL

- Producer side of the convolution element's `data2conv`/`en_in` interface.
- Accepts a raster-order pixel stream (CL_IN channels per pixel, N bits each).
- Buffers KERNEL-1 image rows and emits one packed KERNEL×KERNEL×CL_IN window per valid output position (valid convolution, no padding).
- Output feeds the CE directly, one window per cycle, no backpressure.

---
 rtl/cnn_pkg.sv | 32 +++
 rtl/conv_line_buffer.sv | 30 +++
 rtl/conv_window_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: constant helpers used for port
// sizing, the window tap bit-offset map (common to the window generator and
// the convolution element) and the kernel-size legality check.
package cnn_pkg;

    // Legal kernel sizes are the odd values 1..7.
    localparam int KERNEL_MAX = 7;

    // Ceiling log2, never below 1 so that counters and indices keep a real width.
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        for (int k = 1; k < 32; k++) begin
            if ((1 << bits) < value) begin
                bits = bits + 1;
            end
        end
        return bits;
    endfunction

    // Bit offset of channel ch, tap t inside a packed window.
    // t = r*kernel + c, with r=0 the oldest row and c=0 the oldest column.
    function automatic int tap_offset(input int ch, input int t, input int kernel, input int n);
        return (ch * kernel * kernel + t) * n;
    endfunction

    // True when kernel is one of 1, 3, 5, 7.
    function automatic bit kernel_legal(input int kernel);
        return (kernel >= 1) && (kernel <= KERNEL_MAX) && ((kernel % 2) == 1);
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: the output is the pixel accepted DEPTH enables ago.
// Contents are deliberately not reset; row gating downstream keeps stale
// data out of any emitted window.
module conv_line_buffer
    import cnn_pkg::*;
#(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] mem [DEPTH];

    // Shift the row delay by one position on every accepted pixel.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                mem[k] <= mem[k-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Sliding-window generator feeding the convolution element.
// Takes a raster-order pixel stream, keeps KERNEL-1 rows in chained line
// buffers and emits one packed KERNEL x KERNEL x CL_IN window per valid
// output position, one cycle after the completing pixel. No backpressure.
// Optional build macro WIN_STRIDE2_EN: only even output offsets are emitted
// and win_row/win_col report the stride-2 index.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int CL_IN  = 5,
    parameter int KERNEL = 3,
    parameter int N      = 2,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CL_IN*N-1:0]               pix_in,
    input  logic                             pix_valid,
    input  logic                             sof,
    output logic [CL_IN*KERNEL*KERNEL*N-1:0] win_out,
    output logic                             win_valid,
    output logic [clog2(IMG_H)-1:0]          win_row,
    output logic [clog2(IMG_W)-1:0]          win_col,
    output logic                             frame_done
);

    localparam int PW   = CL_IN * N;
    localparam int RW   = clog2(IMG_H);
    localparam int CW   = clog2(IMG_W);
    localparam int LB_N = (KERNEL > 1) ? KERNEL - 1 : 1;

    if (!kernel_legal(KERNEL)) begin : g_bad_kernel
        $error("conv_window_gen: KERNEL must be 1, 3, 5 or 7");
    end

    logic [RW-1:0] row_cnt, cur_row, off_row, out_row;
    logic [CW-1:0] col_cnt, cur_col, off_col, out_col;
    logic          last_row, last_col, in_window, take;
    logic [PW-1:0] lb_in   [LB_N];
    logic [PW-1:0] lb_out  [LB_N];
    logic [PW-1:0] new_col [KERNEL];
    logic [PW-1:0] win_q   [KERNEL][KERNEL];

    // Line buffer chain: lb_out[j] is the pixel from j+1 rows above.
    assign lb_in[0] = pix_in;
    for (genvar j = 1; j < LB_N; j++) begin : g_lb_link
        assign lb_in[j] = lb_out[j-1];
    end
    if (KERNEL > 1) begin : g_lb
        for (genvar j = 0; j < KERNEL - 1; j++) begin : g_stage
            conv_line_buffer #(.W(PW), .DEPTH(IMG_W)) u_lb (
                .clk  (clk),
                .en   (pix_valid),
                .din  (lb_in[j]),
                .dout (lb_out[j])
            );
        end
    end else begin : g_no_lb
        assign lb_out[0] = '0;
    end

    // Position of the pixel on pix_in (sof forces it to the frame origin) and
    // whether it completes an emitted window.
    always_comb begin
        cur_row   = sof ? '0 : row_cnt;
        cur_col   = sof ? '0 : col_cnt;
        last_row  = (cur_row == RW'(IMG_H - 1));
        last_col  = (cur_col == CW'(IMG_W - 1));
        off_row   = cur_row - RW'(KERNEL - 1);
        off_col   = cur_col - CW'(KERNEL - 1);
        in_window = (cur_row >= RW'(KERNEL - 1)) && (cur_col >= CW'(KERNEL - 1));
`ifdef WIN_STRIDE2_EN
        take      = in_window && !off_row[0] && !off_col[0];
        out_row   = off_row >> 1;
        out_col   = off_col >> 1;
`else
        take      = in_window;
        out_row   = off_row;
        out_col   = off_col;
`endif
    end

    // Newest window column: line-buffer taps on top, the incoming pixel at the bottom.
    always_comb begin
        for (int r = 0; r < KERNEL; r++) begin
            if (r == KERNEL - 1) begin
                new_col[r] = pix_in;
            end else begin
                new_col[r] = lb_out[KERNEL - 2 - r];
            end
        end
    end

    // Raster counters: advance per accepted pixel, wrap at row and frame ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (pix_valid) begin
            if (last_col) begin
                col_cnt <= '0;
                row_cnt <= last_row ? '0 : cur_row + 1'b1;
            end else begin
                col_cnt <= cur_col + 1'b1;
                row_cnt <= cur_row;
            end
        end
    end

    // Window registers: shift left one column and load the new column.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (pix_valid) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][KERNEL-1] <= new_col[r];
            end
        end
    end

    // Registered strobes and output position, one cycle after the pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= pix_valid && take;
            frame_done <= pix_valid && last_row && last_col;
            if (pix_valid && take) begin
                win_row <= out_row;
                win_col <= out_col;
            end
        end
    end

    // Repack the window registers into the channel-major CE format.
    always_comb begin
        win_out = '0;
        for (int i = 0; i < CL_IN; i++) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    win_out[tap_offset(i, r * KERNEL + c, KERNEL, N) +: N] = win_q[r][c][i*N +: N];
                end
            end
        end
    end

endmodule
